// File: rtl/bsg_pkg.sv
// ============================================================================
// Module   : bsg_pkg
// Brief    : Shared constants and types for the bsg_tx bit-stream transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bsg_pkg;

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_DATA1   = 2'd1;
  localparam logic [1:0] ADDR_DATA2   = 2'd2;

  localparam int TXENABLE = 0;
  localparam int INTMSK   = 1;
  localparam int INTFLAG  = 2;
  localparam int STATUS   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bsg_tx_if.sv
// ============================================================================
// Module   : bsg_tx_if
// Brief    : Valid/ready register bus plus interrupt line of bsg_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bsg_tx_if;
  logic       valid;
  logic       write;
  logic [1:0] endereco;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       irq;

  modport master (
    output valid, write, endereco, data_in,
    input  data_out, ready, irq
  );

  modport slave (
    input  valid, write, endereco, data_in,
    output data_out, ready, irq
  );
endinterface

`default_nettype wire

// File: rtl/bsg_gray_encoder.sv
// ============================================================================
// Module   : bsg_gray_encoder
// Brief    : 8-bit combinational binary to Gray code converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_gray_encoder (
  input  wire logic [7:0] i_bin,
  output logic      [7:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

`default_nettype wire

// File: rtl/bsg_tx.sv
// ============================================================================
// Module   : bsg_tx
// Brief    : Ping-pong buffered, Gray-encoded, MSB-first bit-stream DAC driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_tx
  import bsg_pkg::*;
#(
  parameter int         BIT_CYCLES  = 4,
  parameter logic [7:0] MARK_LEVEL  = 8'hFF,
  parameter logic [7:0] SPACE_LEVEL = 8'h00,
  parameter logic [7:0] IDLE_LEVEL  = 8'h80
) (
  input  wire logic       clk,
  input  wire logic       reset,
  bsg_tx_if.slave         bus,
  output logic      [7:0] OUT
);

  localparam int                 c_CYC_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(BIT_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic [7:0]         r_out, w_out_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [c_CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic               w_byte_done;

  logic               r_txen, r_intmsk, r_intflag, r_data_flag;
  logic [7:0]         r_data1, r_data2;
  logic               w_sel;
  logic [7:0]         w_src, w_gray, w_ctrl, w_rdata;
  logic               w_wr;

  function automatic logic [7:0] f_level(input logic b);
    return b ? MARK_LEVEL : SPACE_LEVEL;
  endfunction

  // A load from SHIFT only happens at end of byte, where data_flag is about
  // to toggle, so the encoder must already see the other buffer.
  assign w_sel = r_data_flag ^ (r_state == SHIFT);
  assign w_src = w_sel ? r_data2 : r_data1;

  bsg_gray_encoder u_gray (
    .i_bin  (w_src),
    .o_gray (w_gray)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_out_nxt   = r_out;
    w_bit_nxt   = r_bit;
    w_cyc_nxt   = r_cyc;
    w_byte_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_out_nxt = IDLE_LEVEL;
        if (r_txen) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = w_gray;
          w_bit_nxt   = 3'd0;
          w_cyc_nxt   = '0;
          w_out_nxt   = f_level(w_gray[7]);
        end
      end
      SHIFT: begin
        if (r_cyc == c_CYC_LAST) begin
          w_cyc_nxt = '0;
          if (r_bit == 3'd7) begin
            w_byte_done = 1'b1;
            if (r_txen) begin
              w_shift_nxt = w_gray;
              w_bit_nxt   = 3'd0;
              w_out_nxt   = f_level(w_gray[7]);
            end else begin
              w_state_nxt = IDLE;
              w_out_nxt   = IDLE_LEVEL;
            end
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_out_nxt   = f_level(r_shift[6]);
          end
        end else begin
          w_cyc_nxt = r_cyc + c_CYC_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_out_nxt   = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_out   <= IDLE_LEVEL;
      r_bit   <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
      r_bit   <= w_bit_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  assign w_wr = bus.valid & bus.write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txen      <= 1'b0;
      r_intmsk    <= 1'b0;
      r_intflag   <= 1'b0;
      r_data_flag <= 1'b0;
      r_data1     <= '0;
      r_data2     <= '0;
    end else begin
      if (w_wr && bus.endereco == ADDR_CONTROL) begin
        r_txen   <= bus.data_in[TXENABLE];
        r_intmsk <= bus.data_in[INTMSK];
      end
      if (w_wr && bus.endereco == ADDR_DATA1) r_data1 <= bus.data_in;
      if (w_wr && bus.endereco == ADDR_DATA2) r_data2 <= bus.data_in;
      // Hardware set takes priority over a simultaneous write-1-to-clear.
      if (w_byte_done)
        r_intflag <= 1'b1;
      else if (w_wr && bus.endereco == ADDR_CONTROL && bus.data_in[INTFLAG])
        r_intflag <= 1'b0;
      if (w_byte_done) r_data_flag <= ~r_data_flag;
    end
  end

  always_comb begin
    w_ctrl           = '0;
    w_ctrl[TXENABLE] = r_txen;
    w_ctrl[INTMSK]   = r_intmsk;
    w_ctrl[INTFLAG]  = r_intflag;
    w_ctrl[STATUS]   = (r_state == SHIFT);
  end

  always_comb begin
    w_rdata = '0;
    if (bus.valid) begin
      case (bus.endereco)
        ADDR_CONTROL: w_rdata = w_ctrl;
        ADDR_DATA1:   w_rdata = r_data1;
        ADDR_DATA2:   w_rdata = r_data2;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign bus.data_out = w_rdata;
  assign bus.ready    = 1'b1;
  assign bus.irq      = r_intflag & r_intmsk;
  assign OUT          = r_out;

endmodule

`default_nettype wire

// File: tb/tb_bsg_tx.sv
// ============================================================================
// Module   : tb_bsg_tx
// Brief    : Directed self-checking bench for bsg_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] OUT;
  int         n_chk  = 0;
  int         n_pass = 0;

  bsg_tx_if bus ();

  bsg_tx u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .OUT   (OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b1; bus.endereco = a; bus.data_in = d;
    @(posedge clk);
    #1;
    bus.valid = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b0; bus.endereco = a;
    #1;
    d = bus.data_out;
    bus.valid = 1'b0;
  endtask

  // One clock: sample OUT and STATUS, optionally issue a write over the next edge.
  task automatic cyc_step(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          output logic [7:0] o, output logic st);
    @(negedge clk);
    bus.valid = 1'b1; bus.write = 1'b0; bus.endereco = 2'd0;
    #1;
    o  = OUT;
    st = bus.data_out[3];
    bus.valid = wr; bus.write = wr; bus.endereco = a; bus.data_in = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, o, pat, exp;
    logic       st;
    int         st_cnt, k_irq;
    bit         found;

    bus.valid = 1'b0; bus.write = 1'b0; bus.endereco = 2'd0; bus.data_in = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", OUT, 8'h80);
    check("rst_irq", {7'b0, bus.irq}, 8'h00);
    reset = 1'b0;

    // Register access
    bus_write(2'd1, 8'hA5);
    bus_write(2'd2, 8'h3C);
    bus_write(2'd0, 8'h02);
    bus_write(2'd3, 8'h55);
    bus_read(2'd1, rd); check("rd_data1", rd, 8'hA5);
    bus_read(2'd2, rd); check("rd_data2", rd, 8'h3C);
    bus_read(2'd0, rd); check("rd_ctrl", rd, 8'h02);
    bus_read(2'd3, rd); check("rd_resv", rd, 8'h00);
    @(negedge clk);
    bus.valid = 1'b0; bus.endereco = 2'd1;
    #1 check("rd_novalid", bus.data_out, 8'h00);
    check("ready", {7'b0, bus.ready}, 8'h01);
    bus_write(2'd0, 8'h00);

    // Single byte: 8'h05 -> gray 8'h07
    pat = 8'h07;
    bus_write(2'd1, 8'h05);
    bus_write(2'd0, 8'h01);
    bus_write(2'd0, 8'h00);
    st_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc_step(1'b0, 2'd0, 8'h00, o, st);
      st_cnt += int'(st);
      if (k < 32) begin
        exp = pat[7 - k/4] ? 8'hFF : 8'h00;
        check("single_out", o, exp);
      end else if (k == 32) begin
        check("single_idle", o, 8'h80);
      end
    end
    check("single_status", 8'(st_cnt), 8'd32);
    bus_read(2'd0, rd); check("flag_nomask", rd, 8'h04);
    check("irq_masked", {7'b0, bus.irq}, 8'h00);
    bus_write(2'd0, 8'h04);
    bus_read(2'd0, rd); check("flag_clr", rd, 8'h00);

    // Interrupt latency and clear
    bus_write(2'd0, 8'h02);
    bus_write(2'd0, 8'h03);
    bus_write(2'd0, 8'h02);
    found = 1'b0; k_irq = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(negedge clk);
      if (bus.irq) begin found = 1'b1; k_irq = k; end
    end
    check("irq_latency", 8'(k_irq), 8'd33);
    bus_write(2'd0, 8'h06);
    check("irq_clr", {7'b0, bus.irq}, 8'h00);
    bus_read(2'd0, rd); check("ctrl_after_clr", rd, 8'h02);
    bus_write(2'd0, 8'h00);

    // Ping-pong: D1=00 (gray 00), D2=FF (gray 80)
    bus_write(2'd1, 8'h00);
    bus_write(2'd2, 8'hFF);
    bus_write(2'd0, 8'h01);
    cyc_step(1'b0, 2'd0, 8'h00, o, st);
    check("pp_pre", o, 8'h80);
    st_cnt = 0;
    for (int k = 0; k < 96; k++) begin
      cyc_step(1'b0, 2'd0, 8'h00, o, st);
      st_cnt += int'(st);
      exp = ((k % 64) >= 32 && (k % 64) < 36) ? 8'hFF : 8'h00;
      check("pp_out", o, exp);
    end
    check("pp_status", 8'(st_cnt), 8'd96);
    bus_write(2'd0, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      bus_read(2'd0, rd);
      if (!rd[3]) found = 1'b1;
    end
    check("pp_stop", {7'b0, found}, 8'h01);
    bus_write(2'd0, 8'h04);

    // Buffer isolation: rewrite DATA_1 during the 3rd bit
    bus_write(2'd1, 8'h05);
    bus_write(2'd0, 8'h01);
    bus_write(2'd0, 8'h00);
    for (int k = 0; k < 34; k++) begin
      cyc_step(k == 8, 2'd1, 8'hFF, o, st);
      if (k < 32) begin
        exp = pat[7 - k/4] ? 8'hFF : 8'h00;
        check("iso_out", o, exp);
      end else if (k == 32) begin
        check("iso_idle", o, 8'h80);
      end
    end
    bus_read(2'd1, rd); check("iso_data1", rd, 8'hFF);
    bus_write(2'd0, 8'h04);

    // Reset mid-byte
    bus_write(2'd1, 8'h05);
    bus_write(2'd2, 8'hFF);
    bus_write(2'd0, 8'h03);
    repeat (45) @(negedge clk);
    check("pre_rst_irq", {7'b0, bus.irq}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out", OUT, 8'h80);
    check("mid_rst_irq", {7'b0, bus.irq}, 8'h00);
    bus.valid = 1'b1; bus.write = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.endereco = 2'(a);
      #1 check("mid_rst_reg", bus.data_out, 8'h00);
    end
    bus.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) cyc_step(1'b0, 2'd0, 8'h00, o, st);
    check("post_rst_idle", o, 8'h80);
    check("post_rst_status", {7'b0, st}, 8'h00);
    bus_write(2'd1, 8'h05);
    bus_write(2'd2, 8'hFF);
    bus_write(2'd0, 8'h01);
    bus_write(2'd0, 8'h00);
    for (int k = 0; k < 24; k++) begin
      cyc_step(1'b0, 2'd0, 8'h00, o, st);
      if (k == 0)  check("restart_d1_b7", o, 8'h00);
      if (k == 20) check("restart_d1_b2", o, 8'hFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_tx.md
# bsg_tx

Bit-stream generator transmitter. A CPU programs a control register and two double-buffered data bytes over a simple valid/ready register bus. Each byte is Gray-encoded, then serialized MSB-first into an 8-bit modulated sample stream for a DAC. Buffers alternate automatically (ping-pong), and an interrupt flags each completed byte.

## Interface
- BIT_CYCLES, 4: clock cycles per transmitted bit (≥1).
- MARK_LEVEL, 8'hFF: sample driven for a '1' bit.
- SPACE_LEVEL, 8'h00: sample driven for a '0' bit.
- IDLE_LEVEL, 8'h80: sample driven when not transmitting.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- valid  in  1  bus request.
- write  in  1  1 = write, 0 = read (qualified by valid).
- endereco  in  2  register address.
- data_in  in  8  write data.
- data_out  out  8  read data.
- ready  out  1  bus acknowledge.
- irq  out  1  interrupt = INTFLAG & INTMSK.
- OUT  out  8  modulated sample.

## Operation
- Register map:
  - 0 CONTROL: bit0 TXENABLE (rw), bit1 INTMSK (rw), bit2 INTFLAG (write-1-to-clear), bit3 STATUS (ro, 1 while a byte is shifting), bits7:4 read 0.
  - 1 DATA_1 (rw).
  - 2 DATA_2 (rw).
  - 3 reserved: reads 8'h00, writes ignored.
- Bus:
  - ready is constantly 1; a transfer completes in any cycle with valid=1.
  - Writes take effect at that clock edge.
  - data_out is combinational from endereco and is 8'h00 when valid=0.
- data_flag selects the source buffer (0 = DATA_1, 1 = DATA_2); it resets to 0.
- Encoder: gray = bin ^ (bin >> 1).
- States: IDLE and SHIFT.
  - IDLE → SHIFT when TXENABLE=1. The Gray code of the selected buffer is loaded into the shift register.
  - In SHIFT, OUT = MARK_LEVEL or SPACE_LEVEL according to the current bit (MSB first). Each bit is held for BIT_CYCLES cycles.
- End of byte (after the 8th bit period):
  - data_flag toggles and INTFLAG is set.
  - If TXENABLE=1, the next byte loads from the other buffer with no gap.
  - Otherwise the state returns to IDLE.
- Clearing TXENABLE mid-byte does not abort: the current byte finishes.
- Buffer writes during SHIFT never affect the byte being shifted, since it was latched at load.
- If an INTFLAG set and a CPU clear occur in the same cycle, the set wins.
- In IDLE, OUT = IDLE_LEVEL and STATUS = 0.

## Timing
- Reset, asynchronous and immediate:
  - CONTROL=0, DATA_1=0, DATA_2=0, data_flag=0, state IDLE.
  - OUT=IDLE_LEVEL, irq=0, data_out=0.
- Reset asserted mid-byte aborts the byte. Transmission restarts from DATA_1 only after software sets TXENABLE again.
- TXENABLE written 1 at edge N: the load occurs at edge N+1, and the first bit appears on OUT after edge N+1.
- A byte occupies exactly 8·BIT_CYCLES cycles.
- INTFLAG and irq rise at the edge ending the last bit period. The next byte's first bit appears after that same edge.
- OUT is registered (no combinational path from bus inputs).

## Structure
- Shared package bsg_pkg holds:
  - Address constants ADDR_CONTROL, ADDR_DATA1, ADDR_DATA2.
  - Bit indices TXENABLE, INTMSK, INTFLAG, STATUS.
  - A state enum {IDLE, SHIFT}.
- One natural sub-module: bsg_gray_encoder (8-bit combinational binary→Gray).
- Register bank, bit counter, cycle counter and shift register live in bsg_tx.

## Test plan
- Reset: assert reset mid-byte → OUT=8'h80, irq=0, every register reads 8'h00, within the same cycle.
- Register access: write DATA_1=8'hA5, DATA_2=8'h3C, CONTROL=8'h02 → reads return 8'hA5, 8'h3C, 8'h02; address 3 reads 8'h00.
- Single byte: DATA_1=8'h05 (gray 8'h07); set TXENABLE then clear it after 1 cycle.
  - OUT = 00,00,00,00,00,FF,FF,FF, each for 4 cycles, then 8'h80.
  - STATUS=1 for exactly 32 cycles.
- Ping-pong: DATA_1=8'h00, DATA_2=8'hFF (gray 8'h80), TXENABLE held.
  - OUT = 32 cycles of 8'h00, then FF for 4 cycles, then 00 for 28 cycles.
  - Then 8'h00 repeats, with no idle gap between bytes.
- Interrupt: INTMSK=1; after a byte, irq=1. Writing CONTROL with bit2=1 clears irq next cycle; with INTMSK=0, INTFLAG sets but irq stays 0.
- Buffer isolation: rewrite DATA_1 to 8'hFF during the 3rd bit of its byte → the current byte's output is unchanged.
